// File: rtl/reset_sequencer.sv
// Synchronizes release of a raw async reset, then deasserts NUM_OUT reset domains in index order with a gap.
// Latency: rst_out_n[k] releases SYNC_STAGES + (k+1)*STAGE_DELAY edges after rst rises; no flow control.
module reset_sequencer #(
  parameter int NUM_OUT     = 4,
  parameter int SYNC_STAGES = 2,
  parameter int STAGE_DELAY = 8,
  parameter int HOLD_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sw_rst_req,
  output logic               sw_rst_ack,
  output logic [NUM_OUT-1:0] rst_out_n,
  output logic               all_released,
  output logic               busy
);

  localparam int MAX_DLY = (STAGE_DELAY > HOLD_CYCLES) ? STAGE_DELAY : HOLD_CYCLES;
  localparam int CNT_W   = $clog2(MAX_DLY) + 1;
  localparam int IDX_W   = $clog2(NUM_OUT) + 1;

  localparam logic [1:0] ST_ASSERT  = 2'd0;
  localparam logic [1:0] ST_RELEASE = 2'd1;
  localparam logic [1:0] ST_RUN     = 2'd2;
  localparam logic [1:0] ST_SW_HOLD = 2'd3;

  localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_DELAY - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_OUT - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [1:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_OUT-1:0]     rst_out_n_q, rst_out_n_d;
  logic                   ack_q, ack_d;
  logic                   all_rel_q, all_rel_d;
  logic                   rst_sync;

  assign rst_sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], 1'b1};
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    rst_out_n_d = rst_out_n_q;
    ack_d       = 1'b0;

    case (state_q)
      // Leave ASSERT on the same edge the synchronizer output captures 1.
      ST_ASSERT: begin
        if (sync_q[SYNC_STAGES-2]) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      ST_RELEASE: begin
        if (rst_sync) begin
          if (cnt_q == STAGE_LAST) begin
            cnt_d = '0;
            idx_d = idx_q + IDX_W'(1);
            for (int i = 0; i < NUM_OUT; i++) begin
              if (idx_q == IDX_W'(i)) rst_out_n_d[i] = 1'b1;
            end
            if (idx_q == IDX_LAST) state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_RUN: begin
        if (sw_rst_req) begin
          rst_out_n_d = '0;
          cnt_d       = '0;
          state_d     = ST_SW_HOLD;
        end
      end
      ST_SW_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          ack_d   = 1'b1;
          state_d = ST_RELEASE;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_ASSERT;
    endcase

    all_rel_d = &rst_out_n_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q      <= '0;
      state_q     <= ST_ASSERT;
      cnt_q       <= '0;
      idx_q       <= '0;
      rst_out_n_q <= '0;
      ack_q       <= 1'b0;
      all_rel_q   <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      rst_out_n_q <= rst_out_n_d;
      ack_q       <= ack_d;
      all_rel_q   <= all_rel_d;
    end
  end

  assign rst_out_n    = rst_out_n_q;
  assign sw_rst_ack   = ack_q;
  assign all_released = all_rel_q;
  assign busy         = ~all_rel_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: power-on, async reset, software reset, ignored requests, glitch, minimal config.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sw_rst_req = 1'b0;
  logic       sw_rst_ack;
  logic [3:0] rst_out_n;
  logic       all_released;
  logic       busy;

  logic       sw0 = 1'b0;
  logic       s_ack;
  logic [0:0] s_rst_out_n;
  logic       s_all_released;
  logic       s_busy;

  int n_chk   = 0;
  int n_fail  = 0;
  int k       = 0;
  int ack_cnt = 0;

  always #5 clk = ~clk;

  reset_sequencer #(.NUM_OUT(4), .SYNC_STAGES(2), .STAGE_DELAY(8), .HOLD_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .sw_rst_req(sw_rst_req), .sw_rst_ack(sw_rst_ack),
    .rst_out_n(rst_out_n), .all_released(all_released), .busy(busy)
  );

  reset_sequencer #(.NUM_OUT(1), .SYNC_STAGES(2), .STAGE_DELAY(1), .HOLD_CYCLES(1)) dut_min (
    .clk(clk), .rst(rst), .sw_rst_req(sw0), .sw_rst_ack(s_ack),
    .rst_out_n(s_rst_out_n), .all_released(s_all_released), .busy(s_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and sample 1ns later; k counts edges since the last rst rise.
  task automatic step();
    @(posedge clk);
    #1;
    k++;
    if (sw_rst_ack === 1'b1) ack_cnt++;
  endtask

  task automatic run_to(input int target);
    while (k < target) step();
  endtask

  task automatic check_power_on(input string pfx);
    run_to(9);
    chk({pfx, "_e9"}, {28'd0, rst_out_n}, 32'h0);
    step();
    chk({pfx, "_e10"}, {28'd0, rst_out_n}, 32'h1);
    run_to(18);
    chk({pfx, "_e18"}, {28'd0, rst_out_n}, 32'h3);
    run_to(26);
    chk({pfx, "_e26"}, {28'd0, rst_out_n}, 32'h7);
    run_to(33);
    chk({pfx, "_e33_busy"}, {31'd0, busy}, 32'h1);
    step();
    chk({pfx, "_e34"}, {28'd0, rst_out_n}, 32'hf);
    chk({pfx, "_e34_allrel"}, {31'd0, all_released}, 32'h1);
    chk({pfx, "_e34_busy"}, {31'd0, busy}, 32'h0);
  endtask

  int ack_base;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_n_reset", {28'd0, rst_out_n}, 32'h0);
    chk("allrel_reset", {31'd0, all_released}, 32'h0);
    chk("busy_reset", {31'd0, busy}, 32'h1);
    chk("ack_reset", {31'd0, sw_rst_ack}, 32'h0);
    #4 rst = 1'b1;
    k = 0;

    // Minimal configuration releases its single domain at edge 3.
    run_to(2);
    chk("min_e2", {31'd0, s_rst_out_n}, 32'h0);
    step();
    chk("min_e3", {31'd0, s_rst_out_n}, 32'h1);
    chk("min_e3_allrel", {31'd0, s_all_released}, 32'h1);

    // Power-on sequence with a request at edge 20 that must be ignored.
    run_to(9);
    chk("po_e9", {28'd0, rst_out_n}, 32'h0);
    step();
    chk("po_e10", {28'd0, rst_out_n}, 32'h1);
    run_to(17);
    chk("po_e17", {28'd0, rst_out_n}, 32'h1);
    step();
    chk("po_e18", {28'd0, rst_out_n}, 32'h3);
    run_to(19);
    sw_rst_req = 1'b1;
    step();
    sw_rst_req = 1'b0;
    chk("ign_e20", {28'd0, rst_out_n}, 32'h3);
    run_to(26);
    chk("po_e26", {28'd0, rst_out_n}, 32'h7);
    run_to(33);
    chk("po_e33_allrel", {31'd0, all_released}, 32'h0);
    step();
    chk("po_e34", {28'd0, rst_out_n}, 32'hf);
    chk("po_e34_allrel", {31'd0, all_released}, 32'h1);
    chk("po_e34_busy", {31'd0, busy}, 32'h0);
    chk("ign_no_ack", ack_cnt, 0);

    // Asynchronous reset while in RUN, observed before the next edge.
    run_to(36);
    #3 rst = 1'b0;
    #1;
    chk("async_rst_out_n", {28'd0, rst_out_n}, 32'h0);
    chk("async_allrel", {31'd0, all_released}, 32'h0);
    chk("async_busy", {31'd0, busy}, 32'h1);
    step();
    #4 rst = 1'b1;
    k = 0;
    check_power_on("rerun");

    // Software reset requested at edge E = 35.
    sw_rst_req = 1'b1;
    ack_base = ack_cnt;
    step();
    sw_rst_req = 1'b0;
    chk("sw_e_rst_out_n", {28'd0, rst_out_n}, 32'h0);
    chk("sw_e_allrel", {31'd0, all_released}, 32'h0);
    run_to(38);
    chk("sw_e3_ack", {31'd0, sw_rst_ack}, 32'h0);
    step();
    chk("sw_e4_ack", {31'd0, sw_rst_ack}, 32'h1);
    step();
    chk("sw_e5_ack", {31'd0, sw_rst_ack}, 32'h0);
    run_to(46);
    chk("sw_e11", {28'd0, rst_out_n}, 32'h0);
    step();
    chk("sw_e12", {28'd0, rst_out_n}, 32'h1);
    run_to(70);
    chk("sw_e35", {28'd0, rst_out_n}, 32'h7);
    step();
    chk("sw_e36", {28'd0, rst_out_n}, 32'hf);
    chk("sw_e36_allrel", {31'd0, all_released}, 32'h1);
    chk("sw_ack_count", ack_cnt - ack_base, 1);

    // Software reset at E = 72, interrupted by a sub-cycle rst glitch at E+2.
    sw_rst_req = 1'b1;
    step();
    sw_rst_req = 1'b0;
    ack_base = ack_cnt;
    run_to(74);
    #2 rst = 1'b0;
    #1;
    chk("glitch_rst_out_n", {28'd0, rst_out_n}, 32'h0);
    #2 rst = 1'b1;
    k = 0;
    check_power_on("glitch");
    chk("glitch_no_ack", ack_cnt - ack_base, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
